uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Asynchronous serial receiver using 16x oversampling.
- Consumes the one-clock tick from the team's baud-rate tick generator (its `done` output, configured for 16x the line rate) on `s_tick`.
- Recovers 8N1-style frames (1 start bit, DBIT data bits LSB-first, stop bit(s)) from the `rx` pin.
- Presents each byte with a one-clock strobe to the downstream FIFO/CPU interface.

Parameters:
- DBIT, 8, number of data bits per frame (5..9).
- SB_TICK, 16, oversampling ticks spent in stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- clk  input  1  system clock; all flops rise-edge.
- reset_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- s_tick  input  1  16x oversampling strobe, one clk wide, from the baud-rate generator.
- rx_dout  output  DBIT  received data word, LSB = first bit on the line.
- rx_done_tick  output  1  one-clk strobe: frame complete, rx_dout/frame_err valid.
- frame_err  output  1  stop bit sampled low on the last completed frame.

Behaviour:
- Clock and reset fixed: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Reset values: FSM = IDLE, s_reg = 0, n_reg = 0, shift reg = 0, rx_dout = 0, rx_done_tick = 0, frame_err = 0, both sync flops = 1 (line idle).
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s only.
- Counters:
  - s_reg: 4-bit tick counter, width fixed at 5 bits if SB_TICK > 16.
  - n_reg: bit counter, $clog2(DBIT) bits.
  - Counters advance only on clocks with s_tick = 1. No state change occurs on non-tick clocks except IDLE → START.
- IDLE: when rx_s = 0, go to START with s_reg = 0. This does not wait for s_tick.
- START: on each tick s_reg++. At tick with s_reg = 7 (mid start bit):
  - rx_s = 0 → go to DATA, s_reg = 0, n_reg = 0.
  - rx_s = 1 → false start (glitch), return to IDLE with no strobe.
- DATA: on each tick s_reg++. At s_reg = 15 (mid data bit):
  - Shift rx_s into the MSB of the shift register (right shift), s_reg = 0.
  - If n_reg = DBIT-1 go to STOP, else n_reg++.
- STOP: on each tick s_reg++. At s_reg = SB_TICK-1:
  - Sample rx_s; go to IDLE.
  - Next clock: rx_done_tick = 1, rx_dout = shift reg, frame_err = ~rx_s_sampled.
- rx_done_tick is high exactly one clk per frame. It is asserted even on a framing error.
- rx_dout and frame_err hold their values until the next done strobe.
- Latency: strobe appears 1 clk after the stop-sample tick. Line-to-FSM delay is 2 clks (synchronizer).
- Back-to-back frames: IDLE re-arms the same cycle the STOP sample is taken. A start bit immediately following the stop bit is detected without loss.
- rx held low (break): frame completes with frame_err = 1. The FSM then re-enters START from IDLE repeatedly, each attempt passing the mid-start check. This repeats until rx returns high; no lockup.
- s_tick stuck low: FSM freezes in its current state; no timeout.
- Reset mid-frame: immediate return to reset values. No strobe for the partial frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and lasts 16 ticks.
  - rx_s is sampled at s_reg = 15.
  - Adds output parity_err (1 bit, reset 0), updated with rx_done_tick.
  - parity_err = 1 when the XOR of the data bits and the parity bit is not 0 (even parity).
- Undefined: no PARITY state and no parity_err port. Frame is start + DBIT + stop.

Test Plan:
- Basic receive: DBIT = 8, s_tick = 1 every clk (bit = 16 clks), send 0xA5 with a valid stop → single rx_done_tick, rx_dout = 0xA5, frame_err = 0. No second strobe within 200 idle clks.
- False start: rx low for 4 ticks then high → FSM returns to IDLE, no rx_done_tick. A following 0x3C frame is received correctly.
- Framing error: send 0x81 with stop bit driven 0 → rx_done_tick = 1, rx_dout = 0x81, frame_err = 1. Next frame 0x81 with a good stop → frame_err = 0.
- Back-to-back: 0x00 then 0xFF with no idle gap; s_tick from the generator dividing by 4 → two strobes, values 0x00 then 0xFF, both frame_err = 0.
- Reset mid-frame: assert reset_n = 0 after 3 data bits of 0x55 → outputs are reset values next clk, no strobe. Then 0x55 sent after release → received correctly.
- Parity (UART_RX_PARITY_EN defined): 0x07 with parity bit 1 → parity_err = 0. Same frame with parity bit 0 → parity_err = 1, rx_dout = 0x07.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled serial receiver (start, DBIT data LSB-first,
// optional parity, stop). Define UART_RX_PARITY_EN to add the parity stage.
// Ports: clk, reset_n (async, active-low), rx (async serial line, idle
// high), s_tick (16x baud strobe), rx_dout (received word), rx_done_tick
// (one-clk frame strobe), frame_err (stop bit low),
// parity_err (UART_RX_PARITY_EN only, even parity mismatch).
module uart_rx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            rx,
   input  logic            s_tick,
   output logic [DBIT-1:0] rx_dout,
   output logic            rx_done_tick,
`ifdef UART_RX_PARITY_EN
   output logic            parity_err,
`endif
   output logic            frame_err
);

   localparam int SW = (SB_TICK > 16) ? 5 : 4;
   localparam int NW = $clog2(DBIT);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE, START, DATA, STOP
   } state_t;
`endif

   state_t          state_q, state_n;
   logic [SW-1:0]   s_reg, s_n;
   logic [NW-1:0]   n_reg, n_n;
   logic [DBIT-1:0] b_reg, b_n;
   logic            done_n;
   logic            rx_m, rx_s;
`ifdef UART_RX_PARITY_EN
   logic            p_reg, p_n;
`endif

   // two-flop synchronizer, reset to the idle line level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         s_reg   <= '0;
         n_reg   <= '0;
         b_reg   <= '0;
`ifdef UART_RX_PARITY_EN
         p_reg   <= 1'b0;
`endif
      end else begin
         state_q <= state_n;
         s_reg   <= s_n;
         n_reg   <= n_n;
         b_reg   <= b_n;
`ifdef UART_RX_PARITY_EN
         p_reg   <= p_n;
`endif
      end
   end

   always_comb begin
      state_n = state_q;
      s_n     = s_reg;
      n_n     = n_reg;
      b_n     = b_reg;
      done_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
      p_n     = p_reg;
`endif
      unique case (state_q)
         IDLE: begin
            // start edge is taken without waiting for a tick
            if (!rx_s) begin
               state_n = START;
               s_n     = '0;
            end
         end
         START: begin
            if (s_tick) begin
               if (s_reg == SW'(7)) begin
                  if (!rx_s) begin
                     state_n = DATA;
                     s_n     = '0;
                     n_n     = '0;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  s_n = s_reg + SW'(1);
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_reg == SW'(15)) begin
                  s_n = '0;
                  b_n = {rx_s, b_reg[DBIT-1:1]};
                  if (n_reg == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                     state_n = PARITY;
`else
                     state_n = STOP;
`endif
                  end else begin
                     n_n = n_reg + NW'(1);
                  end
               end else begin
                  s_n = s_reg + SW'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (s_tick) begin
               if (s_reg == SW'(15)) begin
                  s_n     = '0;
                  p_n     = rx_s;
                  state_n = STOP;
               end else begin
                  s_n = s_reg + SW'(1);
               end
            end
         end
`endif
         STOP: begin
            if (s_tick) begin
               if (s_reg == SW'(SB_TICK - 1)) begin
                  // back to IDLE now so a following start bit is not lost
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else begin
                  s_n = s_reg + SW'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // outputs registered one clk after the stop sample
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_dout      <= '0;
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err   <= 1'b0;
`endif
      end else begin
         rx_done_tick <= done_n;
         if (done_n) begin
            rx_dout    <= b_reg;
            frame_err  <= ~rx_s;
`ifdef UART_RX_PARITY_EN
            parity_err <= (^b_reg) ^ p_reg;
`endif
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frames plus hand sequences for false start,
// mid-frame reset; expected bytes go through a scoreboard queue.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rx = 1'b1;
   logic       s_tick;
   logic [7:0] rx_dout;
   logic       rx_done_tick;
   logic       frame_err;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   int div = 1;
   int tcnt = 0;
   int checks = 0;
   int errors = 0;
   int strobes = 0;
   int pushed = 0;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       pbit;
      int         dv;
      int         gap;
      logic       exp_fe;
      logic       exp_pe;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } exp_t;

   vec_t vt[7];
   exp_t q[$];

   uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .rx(rx),
      .s_tick(s_tick),
      .rx_dout(rx_dout),
      .rx_done_tick(rx_done_tick),
`ifdef UART_RX_PARITY_EN
      .parity_err(parity_err),
`endif
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // tick generator: one-clk strobe every div clocks
   always @(posedge clk) begin
      if (tcnt >= div - 1) tcnt <= 0;
      else tcnt <= tcnt + 1;
   end
   assign s_tick = (tcnt >= div - 1);

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rx_done_tick) begin
         exp_t e;
         strobes++;
         if (q.size() == 0) begin
            check("unexpected_strobe", 1, 0);
         end else begin
            e = q.pop_front();
            check("rx_dout", int'(rx_dout), int'(e.d));
            check("frame_err", int'(frame_err), int'(e.fe));
`ifdef UART_RX_PARITY_EN
            check("parity_err", int'(parity_err), int'(e.pe));
`endif
         end
      end
   end

   task automatic bit_wait();
      repeat (16 * div) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, input logic stop,
                       input logic pb);
      rx = 1'b0;
      bit_wait();
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         bit_wait();
      end
`ifdef UART_RX_PARITY_EN
      rx = pb;
      bit_wait();
`else
      if (pb) rx = 1'b1;
`endif
      rx = stop;
      bit_wait();
      rx = 1'b1;
   endtask

   task automatic push(input logic [7:0] d, input logic fe,
                       input logic pe);
      exp_t e;
      e.d  = d;
      e.fe = fe;
      e.pe = pe;
      q.push_back(e);
      pushed++;
   endtask

   initial begin
      vt[0] = '{8'hA5, 1'b1, 1'b0, 1, 200, 1'b0, 1'b0};
      vt[1] = '{8'h81, 1'b0, 1'b0, 1, 40, 1'b1, 1'b0};
      vt[2] = '{8'h81, 1'b1, 1'b0, 1, 40, 1'b0, 1'b0};
      vt[3] = '{8'h00, 1'b1, 1'b0, 4, 0, 1'b0, 1'b0};
      vt[4] = '{8'hFF, 1'b1, 1'b0, 4, 80, 1'b0, 1'b0};
      vt[5] = '{8'h07, 1'b1, 1'b1, 1, 40, 1'b0, 1'b0};
      vt[6] = '{8'h07, 1'b1, 1'b0, 1, 40, 1'b0, 1'b1};

      repeat (3) @(negedge clk);
      check("rst_done", int'(rx_done_tick), 0);
      check("rst_dout", int'(rx_dout), 0);
      check("rst_ferr", int'(frame_err), 0);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);

      for (int k = 0; k < 7; k++) begin
         div = vt[k].dv;
         push(vt[k].data, vt[k].exp_fe, vt[k].exp_pe);
         send(vt[k].data, vt[k].stop, vt[k].pbit);
         repeat (vt[k].gap) @(negedge clk);
         check("strobe_count", strobes, pushed);
      end

      // false start: 4 ticks low then high
      div = 1;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      check("false_start", strobes, pushed);
      push(8'h3C, 1'b0, 1'b0);
      send(8'h3C, 1'b1, 1'b0);
      repeat (40) @(negedge clk);
      check("after_false", strobes, pushed);

      // reset after 3 data bits of 0x55
      rx = 1'b0;
      bit_wait();
      for (int i = 0; i < 3; i++) begin
         rx = ((8'h55 >> i) & 8'h01) != 0;
         bit_wait();
      end
      reset_n = 1'b0;
      #1;
      check("mid_rst_dout", int'(rx_dout), 0);
      check("mid_rst_done", int'(rx_done_tick), 0);
      check("mid_rst_ferr", int'(frame_err), 0);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      repeat (200) @(negedge clk);
      check("mid_rst_strobe", strobes, pushed);
      push(8'h55, 1'b0, 1'b0);
      send(8'h55, 1'b1, 1'b0);
      repeat (40) @(negedge clk);
      check("post_rst", strobes, pushed);
      check("queue_empty", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
